ram_hex_dumper: RTL and testbench

//  Hardware RAM-to-Intel-HEX dump engine downstream of the CPU halt.
//  - On a rising edge of start (the CPU halt), takes the RAM debug port via override_ctrl.
//  - Reads every word and emits one ASCII Intel HEX data record per nonzero word on a byte stream (UART TX).
//  - Finishes with the EOF record.
//  - Produces the same ramcpu.hex content as the simulation dump, in silicon.

---
 rtl/ram_hex_dumper.sv | 179 +++++++++++++++++
 tb/tb_ram_hex_dumper.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_hex_dumper.sv
// ============================================================================
// ram_hex_dumper : walks RAM over the debug port and streams Intel HEX records.
// Optional: DUMP_CRLF_EN selects CR+LF line endings (default LF only).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_hex_dumper #(
  parameter int ADDR_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        override_ctrl,
  output logic [31:0] iaddr,
  output logic        iren,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EMIT = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_EOF  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [13:0] LAST_IDX = 14'(ADDR_WORDS - 1);

`ifdef DUMP_CRLF_EN
  localparam logic [4:0] DATA_LAST = 5'd20;
  localparam logic [4:0] EOF_LAST  = 5'd12;
`else
  localparam logic [4:0] DATA_LAST = 5'd19;
  localparam logic [4:0] EOF_LAST  = 5'd11;
`endif

  logic [2:0]  state_q, state_d;
  logic [13:0] idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        start_q, start_d;

  logic [15:0] rec_addr;
  logic [7:0]  csum;
  logic [7:0]  eol_byte;
  logic [7:0]  data_byte;
  logic [7:0]  eof_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  assign rec_addr = {idx_q, 2'b00};
  assign csum     = 8'h00 - (8'h04 + rec_addr[15:8] + rec_addr[7:0] +
                    data_q[31:24] + data_q[23:16] + data_q[15:8] + data_q[7:0]);

`ifdef DUMP_CRLF_EN
  // CR precedes the final LF of each record.
  assign eol_byte = ((state_q == S_EMIT && cnt_q == DATA_LAST) ||
                     (state_q == S_EOF  && cnt_q == EOF_LAST)) ? 8'h0A : 8'h0D;
`else
  assign eol_byte = 8'h0A;
`endif

  always_comb begin
    data_byte = eol_byte;
    case (cnt_q)
      5'd0:  data_byte = 8'h3A;
      5'd1:  data_byte = 8'h30;
      5'd2:  data_byte = 8'h34;
      5'd3:  data_byte = hex_ascii(rec_addr[15:12]);
      5'd4:  data_byte = hex_ascii(rec_addr[11:8]);
      5'd5:  data_byte = hex_ascii(rec_addr[7:4]);
      5'd6:  data_byte = hex_ascii(rec_addr[3:0]);
      5'd7:  data_byte = 8'h30;
      5'd8:  data_byte = 8'h30;
      5'd9:  data_byte = hex_ascii(data_q[31:28]);
      5'd10: data_byte = hex_ascii(data_q[27:24]);
      5'd11: data_byte = hex_ascii(data_q[23:20]);
      5'd12: data_byte = hex_ascii(data_q[19:16]);
      5'd13: data_byte = hex_ascii(data_q[15:12]);
      5'd14: data_byte = hex_ascii(data_q[11:8]);
      5'd15: data_byte = hex_ascii(data_q[7:4]);
      5'd16: data_byte = hex_ascii(data_q[3:0]);
      5'd17: data_byte = hex_ascii(csum[7:4]);
      5'd18: data_byte = hex_ascii(csum[3:0]);
      default: data_byte = eol_byte;
    endcase
  end

  // ":00000001FF" followed by the line ending.
  always_comb begin
    eof_byte = eol_byte;
    if (cnt_q == 5'd0)                         eof_byte = 8'h3A;
    else if (cnt_q <= 5'd7)                    eof_byte = 8'h30;
    else if (cnt_q == 5'd8)                    eof_byte = 8'h31;
    else if (cnt_q == 5'd9 || cnt_q == 5'd10)  eof_byte = 8'h46;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    start_d = start;
    case (state_q)
      S_IDLE: begin
        idx_d = 14'd0;
        cnt_d = 5'd0;
        if (start && !start_q) state_d = S_READ;
      end
      S_READ: begin
        if (!iwait) begin
          data_d  = iload;
          cnt_d   = 5'd0;
          state_d = (iload == 32'd0) ? S_NEXT : S_EMIT;
        end
      end
      S_EMIT: begin
        if (tx_ready) begin
          if (cnt_q == DATA_LAST) state_d = S_NEXT;
          else                    cnt_d   = cnt_q + 5'd1;
        end
      end
      S_NEXT: begin
        cnt_d = 5'd0;
        if (idx_q == LAST_IDX) begin
          state_d = S_EOF;
        end else begin
          idx_d   = idx_q + 14'd1;
          state_d = S_READ;
        end
      end
      S_EOF: begin
        if (tx_ready) begin
          if (cnt_q == EOF_LAST) state_d = S_DONE;
          else                   cnt_d   = cnt_q + 5'd1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 14'd0;
      data_q  <= 32'd0;
      cnt_q   <= 5'd0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign busy          = (state_q == S_READ) || (state_q == S_EMIT) ||
                         (state_q == S_NEXT) || (state_q == S_EOF);
  assign override_ctrl = busy;
  assign done          = (state_q == S_DONE);
  assign iren          = (state_q == S_READ);
  assign iaddr         = {16'd0, idx_q, 2'b00};
  assign tx_valid      = (state_q == S_EMIT) || (state_q == S_EOF);
  assign tx_data       = (state_q == S_EMIT) ? data_byte :
                         (state_q == S_EOF)  ? eof_byte  : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_ram_hex_dumper.sv
// ============================================================================
// tb_ram_hex_dumper : scoreboard bench for ram_hex_dumper with a small RAM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_hex_dumper;

  localparam int ADDR_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic        override_ctrl;
  logic [31:0] iaddr;
  logic        iren;
  logic        iwait;
  logic [31:0] iload;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;

  ram_hex_dumper #(.ADDR_WORDS(ADDR_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .override_ctrl(override_ctrl), .iaddr(iaddr), .iren(iren),
    .iwait(iwait), .iload(iload),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model with a programmable number of wait cycles per read
  logic [31:0] mem [ADDR_WORDS];
  int          wait_n = 0;
  int          wcnt = 0;
  bit          rand_ready = 1'b0;

  assign iload = mem[iaddr[5:2]];
  assign iwait = iren && (wcnt < wait_n);

  always @(posedge clk) begin
    if (!iren)      wcnt <= 0;
    else if (iwait) wcnt <= wcnt + 1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  bit         sb_en = 1'b0;
  int         acc_cnt = 0;
  int         reads = 0;
  int         stall_viol = 0;
  int         hold_viol = 0;
  int         addr_viol = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_iren = 1'b0, prev_iwait = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_iren  = 1'b0;
    end else begin
      if (prev_valid && !prev_ready && (!tx_valid || tx_data != prev_data)) stall_viol++;
      if (prev_iren && prev_iwait && !iren) hold_viol++;
      if (iren && !iwait) begin
        if (iaddr != 32'(reads * 4)) addr_viol++;
        reads++;
      end
      if (sb_en && tx_valid && tx_ready) begin
        acc_cnt++;
        // 0x100 cannot be a byte, so an unexpected extra byte always flags
        if (exp_q.size() == 0) check("extra_byte", {24'd0, tx_data}, 32'h100);
        else                   check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_iren  = iren;
      prev_iwait = iwait;
    end
  end

  task automatic push_rec(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef DUMP_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < ADDR_WORDS; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_override"}, {31'd0, override_ctrl}, 32'd0);
    check({tag, "_iren"},     {31'd0, iren},          32'd0);
    check({tag, "_iaddr"},    iaddr,                  32'd0);
    check({tag, "_txvalid"},  {31'd0, tx_valid},      32'd0);
    check({tag, "_txdata"},   {24'd0, tx_data},       32'd0);
    check({tag, "_busy"},     {31'd0, busy},          32'd0);
    check({tag, "_done"},     {31'd0, done},          32'd0);
  endtask

  task automatic run_dump(input string tag);
    reads = 0; acc_cnt = 0; stall_viol = 0; hold_viol = 0; addr_viol = 0;
    sb_en = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4000 && !(done && exp_q.size() == 0); i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_done"},      {31'd0, done},          32'd1);
    check({tag, "_override"},  {31'd0, override_ctrl}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},          32'd0);
    check({tag, "_iren"},      {31'd0, iren},          32'd0);
    check({tag, "_txvalid"},   {31'd0, tx_valid},      32'd0);
    check({tag, "_remaining"}, 32'(exp_q.size()),      32'd0);
    check({tag, "_reads"},     32'(reads),             32'(ADDR_WORDS));
    check({tag, "_addr_seq"},  32'(addr_viol),         32'd0);
    check({tag, "_stall"},     32'(stall_viol),        32'd0);
    check({tag, "_iren_hold"}, 32'(hold_viol),         32'd0);
  endtask

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    // start already high when reset releases must not trigger a dump
    repeat (5) @(posedge clk);
    #1;
    check("start_high_release_busy", {31'd0, busy}, 32'd0);

    // all-zero RAM: only the EOF record
    push_rec(":00000001FF");
    run_dump("zero_ram");

    do_reset();
    mem[0] = 32'h0000_0013;
    push_rec(":0400000000000013E9");
    push_rec(":00000001FF");
    run_dump("word0");

    do_reset();
    clear_mem();
    mem[4] = 32'hDEAD_BEEF;
    push_rec(":04001000DEADBEEFB4");
    push_rec(":00000001FF");
    run_dump("word4");

    // start edges after completion are ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("post_done_done", {31'd0, done}, 32'd1);
    check("post_done_busy", {31'd0, busy}, 32'd0);

    do_reset();
    rand_ready = 1'b1;
    push_rec(":04001000DEADBEEFB4");
    push_rec(":00000001FF");
    run_dump("word4_stall");
    rand_ready = 1'b0;

    do_reset();
    clear_mem();
    mem[0] = 32'h0000_0013;
    wait_n = 5;
    push_rec(":0400000000000013E9");
    push_rec(":00000001FF");
    run_dump("iwait5");
    wait_n = 0;

    do_reset();
    mem[15] = 32'h0000_0001;
    push_rec(":0400000000000013E9");
    push_rec(":04003C0000000001BF");
    push_rec(":00000001FF");
    run_dump("first_last");

    // reset while the 7th byte of a record is on the wire
    do_reset();
    clear_mem();
    mem[0] = 32'h0000_0013;
    push_rec(":0400000000000013E9");
    reads = 0; acc_cnt = 0;
    sb_en = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 2000 && acc_cnt < 6; i++) begin
      @(posedge clk); #1;
    end
    check("abort_bytes_before", 32'(acc_cnt), 32'd6);
    sb_en = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    push_rec(":0400000000000013E9");
    push_rec(":00000001FF");
    run_dump("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
